// File: rtl/lcd_cmd_queue_pkg.sv
// Shared LCD_CTRL command encodings, command width and queue FSM state codes.
package lcd_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE   = 3'd0,
    SHIFT_UP    = 3'd1,
    SHIFT_DOWN  = 3'd2,
    SHIFT_LEFT  = 3'd3,
    SHIFT_RIGHT = 3'd4,
    MAX         = 3'd5,
    MIN         = 3'd6,
    AVG         = 3'd7
  } lcd_cmd_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_GAP   = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  function automatic logic is_write(input logic [CMD_W-1:0] c);
    return c == CMD_WRITE;
  endfunction

endpackage

// File: rtl/lcd_cmd_queue_if.sv
// Host push channel, LCD_CTRL command channel and queue status in one bundle.
interface lcd_cmd_queue_if #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 3
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic [LVL_W-1:0] level;
  logic [7:0]       issued;

  // master = host plus LCD_CTRL side; slave = the queue itself
  modport master (
    output in_cmd, in_valid, busy, done,
    input  in_ready, cmd, cmd_valid, level, issued
  );

  modport slave (
    input  in_cmd, in_valid, busy, done,
    output in_ready, cmd, cmd_valid, level, issued
  );

endinterface

// File: rtl/lcd_cmd_queue_fifo.sv
// Registered-write FIFO with combinational head; no bypass, so a push is
// visible at the head one cycle later. Full blocks push, empty blocks pop.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && level == '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && full));

endmodule

// File: rtl/lcd_cmd_queue.sv
// Buffers host commands and feeds LCD_CTRL one at a time: 1 cycle head-to-cmd_valid,
// 3 cycles minimum spacing, issue gated by busy and, after WRITE, by done.
module lcd_cmd_queue
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CMD_W = lcd_pkg::CMD_W
) (
  input logic           clk,
  input logic           reset,
  lcd_cmd_queue_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  state_t           state;
  logic [CMD_W-1:0] head;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid_q;
  logic [7:0]       issued_q;

  assign bus.in_ready  = !full;
  assign bus.level     = level;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.issued    = issued_q;

  assign push = bus.in_valid && !full;
  // busy only matters while idle; the FIFO never sees a pop when empty
  assign pop  = (state == ST_IDLE) && !bus.busy && (level != '0);

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.in_cmd),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .full     (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      issued_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cmd_q       <= head;
            cmd_valid_q <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cmd_valid_q <= 1'b0;
          issued_q    <= issued_q + 8'd1;
          state       <= is_write(cmd_q) ? ST_HOLD : ST_GAP;
        end
        // dead cycle lets LCD_CTRL raise busy before we look at it again
        ST_GAP: begin
          state <= ST_IDLE;
        end
        ST_HOLD: begin
          if (bus.done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Randomised and directed bench for lcd_cmd_queue against a queue-and-timing model.
module tb_lcd_cmd_queue;
  import lcd_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  lcd_cmd_queue_if #(.DEPTH(DEPTH), .CMD_W(CW)) bus();

  lcd_cmd_queue #(.DEPTH(DEPTH), .CMD_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a queue of commands plus the timing rules for when an issue may happen.
  int m_q[$];
  int m_cmd       = 0;
  int m_vld       = 0;
  int m_issued    = 0;
  int m_next_ok   = 0;
  int m_hold      = 0;
  int m_hold_from = 0;
  int cyc         = 0;

  always @(posedge clk or posedge reset) begin : model
    int sz0;
    int c;
    if (reset) begin
      m_q.delete();
      m_cmd = 0; m_vld = 0; m_issued = 0;
      m_next_ok = 0; m_hold = 0; m_hold_from = 0; cyc = 0;
    end else begin
      cyc++;
      sz0 = m_q.size();
      if (m_vld != 0) begin
        m_vld = 0;
        m_issued = (m_issued + 1) % 256;
      end
      if (m_hold != 0 && cyc >= m_hold_from && bus.done === 1'b1) begin
        m_hold = 0;
        m_next_ok = cyc + 1;
      end
      if (m_hold == 0 && cyc >= m_next_ok && bus.busy === 1'b0 && sz0 > 0) begin
        c = m_q.pop_front();
        m_cmd = c;
        m_vld = 1;
        m_next_ok = cyc + 3;
        if (c == 0) begin
          m_hold = 1;
          m_hold_from = cyc + 2;
        end
      end
      if (bus.in_valid === 1'b1 && sz0 < DEPTH) m_q.push_back(int'(bus.in_cmd));
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset === 1'b0) begin
      chk("cmd_valid", int'(bus.cmd_valid), m_vld);
      chk("cmd", int'(bus.cmd), m_cmd);
      chk("level", int'(bus.level), m_q.size());
      chk("issued", int'(bus.issued), m_issued);
      chk("in_ready", int'(bus.in_ready), int'(m_q.size() != DEPTH));
    end
  end

  // Log of every issued command and the edge index that issued it.
  int tcyc = 0;
  int log_cmd[$];
  int log_cyc[$];
  always @(posedge clk) tcyc++;
  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) begin
      log_cmd.push_back(int'(bus.cmd));
      log_cyc.push_back(tcyc);
    end
  end

  function automatic int logc(input int i);
    return (i < log_cmd.size()) ? log_cmd[i] : -1;
  endfunction

  function automatic int logt(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1000;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input int c);
    bus.in_valid = 1'b1;
    bus.in_cmd   = CW'(c);
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("push_timeout", int'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int b;
    int t0;
    int te;
    int bp_exp[9];
    int busy_pct;
    bp_exp = '{1, 2, 3, 4, 5, 6, 7, 1, 2};

    bus.in_valid = 1'b0;
    bus.in_cmd   = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_cmd", int'(bus.cmd), 0);
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_issued", int'(bus.issued), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // basic issue
    b = log_cmd.size();
    push(3);
    t0 = tcyc;
    push(1);
    push(7);
    idle(12);
    chk("basic_count", log_cmd.size() - b, 3);
    chk("basic_cmd0", logc(b), 3);
    chk("basic_cmd1", logc(b + 1), 1);
    chk("basic_cmd2", logc(b + 2), 7);
    chk("basic_latency", logt(b) - t0, 1);
    chk("basic_gap1", logt(b + 1) - logt(b), 3);
    chk("basic_gap2", logt(b + 2) - logt(b + 1), 3);
    chk("basic_issued", int'(bus.issued), 3);
    chk("model_basic_issued", m_issued, 3);

    // backpressure
    do_reset();
    bus.busy = 1'b1;
    for (int i = 0; i < 8; i++) push(bp_exp[i]);
    chk("bp_level", int'(bus.level), 8);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("model_bp_level", m_q.size(), 8);
    b = log_cmd.size();
    bus.in_valid = 1'b1;
    bus.in_cmd   = CW'(2);
    idle(3);
    chk("bp_held_level", int'(bus.level), 8);
    chk("bp_no_issue", log_cmd.size() - b, 0);
    bus.busy = 1'b0;
    push(2);
    idle(40);
    chk("bp_count", log_cmd.size() - b, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("bp_order%0d", i), logc(b + i), bp_exp[i]);

    // WRITE hold
    do_reset();
    b = log_cmd.size();
    push(0);
    push(5);
    idle(10);
    chk("wr_count", log_cmd.size() - b, 1);
    chk("wr_cmd0", logc(b), 0);
    chk("wr_level", int'(bus.level), 1);
    bus.done = 1'b1;
    te = tcyc + 1;
    @(negedge clk);
    bus.done = 1'b0;
    idle(6);
    chk("wr_cmd1", logc(b + 1), 5);
    chk("wr_exit", logt(b + 1) - te, 1);
    chk("wr_issued", int'(bus.issued), 2);
    chk("model_wr_issued", m_issued, 2);

    // simultaneous push and pop
    do_reset();
    bus.busy = 1'b1;
    b = log_cmd.size();
    push(2);
    push(3);
    push(4);
    chk("pp_level_pre", int'(bus.level), 3);
    bus.busy     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_cmd   = CW'(5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pp_level", int'(bus.level), 3);
    chk("pp_valid", int'(bus.cmd_valid), 1);
    idle(15);
    chk("pp_o0", logc(b), 2);
    chk("pp_o1", logc(b + 1), 3);
    chk("pp_o2", logc(b + 2), 4);
    chk("pp_o3", logc(b + 3), 5);

    // reset in the middle of a drain
    do_reset();
    bus.busy = 1'b1;
    for (int i = 1; i <= 5; i++) push(i);
    bus.busy = 1'b0;
    @(negedge clk);
    chk("rd_pre_valid", int'(bus.cmd_valid), 1);
    chk("rd_pre_level", int'(bus.level), 4);
    #1 reset = 1'b1;
    #1;
    chk("rd_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rd_level", int'(bus.level), 0);
    chk("rd_in_ready", int'(bus.in_ready), 1);
    chk("rd_cmd", int'(bus.cmd), 0);
    @(negedge clk);
    reset = 1'b0;
    b = log_cmd.size();
    idle(20);
    chk("rd_no_stale", log_cmd.size() - b, 0);

    // random traffic
    for (int blk = 0; blk < 6; blk++) begin
      busy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 85 : 40);
      for (int i = 0; i < 500; i++) begin
        bus.in_valid = ($urandom_range(0, 99) < 60);
        bus.in_cmd   = CW'($urandom_range(0, 7));
        bus.busy     = ($urandom_range(0, 99) < busy_pct);
        bus.done     = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
      if (blk == 3) begin
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b1;
    idle(40);
    chk("rand_drained", int'(bus.level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_queue.md
# lcd_cmd_queue

Command buffer that sits directly upstream of `LCD_CTRL` and drives its `cmd`/`cmd_valid` inputs. It accepts image-operation commands from a host with a valid/ready handshake and stores them in a small FIFO. It issues them one at a time, only while `LCD_CTRL` reports not busy. After a WRITE command it withholds further commands until `LCD_CTRL` signals `done`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CMD_W`, 3: command width; must match `LCD_CTRL.cmd`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_cmd`  in  CMD_W  host command.
- `in_valid`  in  1  host command present.
- `in_ready`  out  1  queue can accept; equals `level != DEPTH`.
- `busy`  in  1  `LCD_CTRL.busy`.
- `done`  in  1  `LCD_CTRL.done`.
- `cmd`  out  CMD_W  registered command to `LCD_CTRL`.
- `cmd_valid`  out  1  registered; one-cycle pulse per issued command.
- `level`  out  clog2(DEPTH+1)  entries currently stored.
- `issued`  out  8  count of commands issued since reset; wraps 255→0.

## Operation
- Push: a command is written when `in_valid && in_ready` at a rising edge.
- There is no pass-through. A command pushed in cycle t is eligible for issue from cycle t+1.
- FIFO read and write pointers wrap modulo DEPTH. `level` tracks occupancy.
- A push and a pop in the same cycle leave `level` unchanged.
- A pop never occurs at `level == 0`. A push never occurs at `level == DEPTH`.
- Commands are issued strictly in push order.
- FSM states: IDLE, ISSUE, GAP, HOLD.
  - IDLE: if `!busy && level != 0`, pop the head, load it into `cmd`, set `cmd_valid = 1`, go to ISSUE. Otherwise stay.
  - ISSUE: clear `cmd_valid`, increment `issued`. If the issued command equals CMD_WRITE (0), go to HOLD; otherwise go to GAP.
  - GAP: one dead cycle so `LCD_CTRL` can raise `busy`; go to IDLE.
  - HOLD: wait for `done == 1`, then go to IDLE. Pushes continue to be accepted meanwhile.
- `done` is ignored outside HOLD.
- `busy` is sampled only in IDLE.
- `cmd` keeps its last issued value until the next issue.

## Timing
- Reset values (asynchronous): `cmd = 0`, `cmd_valid = 0`, `level = 0`, `issued = 0`, `in_ready = 1`, FSM = IDLE, pointers = 0.
- Reset asserted mid-operation discards all queued commands immediately. A `cmd_valid` pulse in flight is cut low asynchronously.
- Issue latency: head present and `busy = 0` in cycle t gives `cmd_valid = 1` in cycle t+1.
- Minimum issue spacing is 3 cycles (ISSUE, GAP, IDLE), even when `busy` stays 0.
- `busy` held high blocks issue indefinitely. Commands accumulate until full, then `in_ready = 0`.
- `in_ready` is combinational from `level` only. It does not depend on `in_valid` or on a same-cycle pop.
- HOLD exit: `done` high at edge e gives IDLE after e. The earliest next `cmd_valid` is at e+2.

## Structure
- Shared package `lcd_pkg`:
  - command encodings: CMD_WRITE = 0, SHIFT_UP = 1, SHIFT_DOWN = 2, SHIFT_LEFT = 3, SHIFT_RIGHT = 4, MAX = 5, MIN = 6, AVG = 7;
  - `CMD_W`;
  - the FSM state enum.
- One sub-module, `lcd_cmd_fifo`: synchronous-write FIFO with push, pop, head, level and full outputs, and asynchronous reset.
- The top module holds the FSM, the output registers and the `issued` counter.

## Test plan
- Reset check: after reset, `cmd = 0`, `cmd_valid = 0`, `level = 0`, `issued = 0`, `in_ready = 1`. Re-asserting reset mid-cycle clears the outputs without waiting for a clock edge.
- Basic issue with `busy = 0`: push 3, 1, 7 → `cmd_valid` pulses one cycle each with `cmd` = 3, 1, 7, pulses 3 cycles apart, final `issued = 3`.
- Backpressure: hold `busy = 1` and push 9 commands (1..7, 1, 2) → `in_ready` falls after the 8th, `level = 8`, the 9th is held by the host. Release `busy` → drain order 1..7, 1, then 2.
- WRITE hold: push 0, then 5 → `cmd = 0` is issued and 5 is not issued, with `level = 1`, until `done` pulses. Then 5 issues 2 cycles later and `issued = 2`.
- Simultaneous push/pop at `level = 3` → `level` stays 3; FIFO order preserved.
- Reset mid-drain at `level = 4`, with `cmd_valid` high → `cmd_valid = 0` and `level = 0` immediately. No stale command is issued afterwards.
